// File: rtl/scaler_accumulator.sv
// Per-channel rising-edge counters over an internal-period or PPS gate window.
// Each gate end latches the full bank, which is then read through a registered port.
module scaler_accumulator #(
    parameter int NCH    = 32,
    parameter int WIDTH  = 16,
    parameter int PERIOD = 33000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NCH-1:0]   scal_i,
    input  logic             pps_i,
    input  logic             use_pps_i,
    input  logic             rd_i,
    input  logic [4:0]       addr_i,
    input  logic             ack_i,
    output logic [WIDTH-1:0] dat_o,
    output logic             dat_valid_o,
    output logic             sat_o,
    output logic             new_o,
    output logic             missed_o,
    output logic             gate_o
);

    localparam int              PW   = 26;
    localparam logic [PW-1:0]   LAST = PW'(PERIOD - 1);
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [NCH-1:0]   scal_q;
    logic [NCH-1:0]   edges;
    logic [NCH-1:0]   satl;
    logic [WIDTH-1:0] cnt     [NCH];
    logic [WIDTH-1:0] cnt_nxt [NCH];
    logic [WIDTH-1:0] latch   [NCH];
    logic [PW-1:0]    pcnt;
    logic             pps_q;
    logic             pps_rise;
    logic             use_pps_q;
    logic             gate;

    assign edges  = scal_i & ~scal_q;
    // Mode select is registered so a mid-gate change applies from the next cycle.
    assign gate   = use_pps_q ? pps_rise : (pcnt == LAST);
    assign gate_o = gate;

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            cnt_nxt[n] = cnt[n];
            if (edges[n] && (cnt[n] != MAXV)) begin
                cnt_nxt[n] = cnt[n] + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scal_q    <= '0;
            pps_q     <= 1'b0;
            pps_rise  <= 1'b0;
            use_pps_q <= 1'b0;
            pcnt      <= '0;
        end else begin
            scal_q    <= scal_i;
            pps_q     <= pps_i;
            pps_rise  <= pps_i & ~pps_q;
            use_pps_q <= use_pps_i;
            if (gate || (pcnt == LAST)) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PW'(1);
            end
        end
    end

    // The edge seen in the gate-end cycle is folded into the closing window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            satl <= '0;
            for (int n = 0; n < NCH; n++) begin
                cnt[n]   <= '0;
                latch[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NCH; n++) begin
                if (gate) begin
                    cnt[n]   <= '0;
                    latch[n] <= cnt_nxt[n];
                    satl[n]  <= (cnt_nxt[n] == MAXV);
                end else begin
                    cnt[n]   <= cnt_nxt[n];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat_o       <= '0;
            dat_valid_o <= 1'b0;
            sat_o       <= 1'b0;
        end else begin
            dat_valid_o <= rd_i;
            if (rd_i) begin
                dat_o <= latch[addr_i];
                sat_o <= satl[addr_i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            new_o    <= 1'b0;
            missed_o <= 1'b0;
        end else begin
            if (gate) begin
                new_o <= 1'b1;
                if (new_o && !ack_i) begin
                    missed_o <= 1'b1;
                end
            end else if (ack_i) begin
                new_o    <= 1'b0;
                missed_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scaler_accumulator.sv
// Bench for scaler_accumulator: a 16-bit and a 4-bit instance share one stimulus stream.
module tb_scaler_accumulator;

    localparam int PER = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] scal;
    logic        pps, use_pps, rd, ack;
    logic [4:0]  addr;

    logic [15:0] d16;
    logic [3:0]  d4;
    logic        v16, s16, n16, m16, g16;
    logic        v4, s4, n4, m4, g4;

    int n_chk  = 0;
    int n_fail = 0;
    int tcyc   = 0;

    scaler_accumulator #(.NCH(32), .WIDTH(16), .PERIOD(PER)) u16 (
        .clk_i(clk), .rst_i(rst), .scal_i(scal), .pps_i(pps), .use_pps_i(use_pps),
        .rd_i(rd), .addr_i(addr), .ack_i(ack), .dat_o(d16), .dat_valid_o(v16),
        .sat_o(s16), .new_o(n16), .missed_o(m16), .gate_o(g16));

    scaler_accumulator #(.NCH(32), .WIDTH(4), .PERIOD(PER)) u4 (
        .clk_i(clk), .rst_i(rst), .scal_i(scal), .pps_i(pps), .use_pps_i(use_pps),
        .rd_i(rd), .addr_i(addr), .ack_i(ack), .dat_o(d4), .dat_valid_o(v4),
        .sat_o(s4), .new_o(n4), .missed_o(m4), .gate_o(g4));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: raw per-window edge totals; saturation applied only when read.
    int        win [32];
    int        lat [32];
    bit [31:0] prev_scal;
    bit        prev_pps, rise_pend, mode;
    int        pcyc;
    bit        e_gate, e_new, e_missed, e_valid;
    int        e_raw;

    task automatic model_clear();
        for (int n = 0; n < 32; n++) begin
            win[n] = 0;
            lat[n] = 0;
        end
        prev_scal = '0; prev_pps = 0; rise_pend = 0; mode = 0; pcyc = 0;
        e_gate = 0; e_new = 0; e_missed = 0; e_valid = 0; e_raw = 0;
    endtask

    task automatic model_step();
        bit [31:0] e;
        bit        g;
        e = scal & ~prev_scal;
        g = e_gate;
        e_valid = rd;
        if (rd) e_raw = lat[addr];
        for (int n = 0; n < 32; n++) begin
            if (g) begin
                lat[n] = win[n] + int'(e[n]);
                win[n] = 0;
            end else begin
                win[n] = win[n] + int'(e[n]);
            end
        end
        if (g) begin
            if (e_new && !ack) e_missed = 1;
            e_new = 1;
        end else if (ack) begin
            e_new = 0;
            e_missed = 0;
        end
        prev_scal = scal;
        if (g || pcyc == PER - 1) pcyc = 0;
        else pcyc = pcyc + 1;
        rise_pend = pps & ~prev_pps;
        prev_pps  = pps;
        mode      = use_pps;
        e_gate    = mode ? rise_pend : (pcyc == PER - 1);
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_clear();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("gate16", g16, e_gate);
            chk("gate4", g4, e_gate);
            chk("new16", n16, e_new);
            chk("new4", n4, e_new);
            chk("missed16", m16, e_missed);
            chk("missed4", m4, e_missed);
            chk("valid16", v16, e_valid);
            chk("valid4", v4, e_valid);
            if (e_valid) begin
                chk("dat16", d16, (e_raw > 65535) ? 65535 : e_raw);
                chk("sat16", s16, (e_raw >= 65535) ? 1 : 0);
                chk("dat4", d4, (e_raw > 15) ? 15 : e_raw);
                chk("sat4", s4, (e_raw >= 15) ? 1 : 0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        tcyc++;
    endtask

    task automatic to(input int t);
        while (tcyc < t) step();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gate"}, g16, 0);
        chk({nm, "_new"}, n16, 0);
        chk({nm, "_missed"}, m16, 0);
        chk({nm, "_valid"}, v16, 0);
        chk({nm, "_dat"}, d16, 0);
        chk({nm, "_sat"}, s16, 0);
        chk({nm, "_dat4"}, d4, 0);
    endtask

    initial begin
        rst = 1; scal = '0; pps = 0; use_pps = 0; rd = 0; ack = 0; addr = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 0;
        tcyc = 0;

        // Ten single-cycle pulses on channel 3 in the first window.
        for (int t = 0; t < 20; t++) begin
            to(t);
            scal[3] = (t % 2 == 0);
        end
        to(20); scal[3] = 0;
        to(98); chk("t1_nogate_98", g16, 0);
        to(99); chk("t1_gate_99", g16, 1);
        to(100); chk("t1_new", n16, 1);
        rd = 1; addr = 5'd3;
        to(101); chk("t1_valid", v16, 1); chk("t1_rd3", d16, 10);
        addr = 5'd5;
        to(102); chk("t1_rd5", d16, 0);
        rd = 0;

        // Held level, pulse on the gate-end cycle, and saturation on channel 31.
        to(110); scal[0] = 1;
        for (int t = 120; t < 160; t++) begin
            to(t);
            scal[31] = (t % 2 == 0);
        end
        to(160); scal[0] = 0; scal[31] = 0; ack = 1;
        to(161); ack = 0; chk("t2_ack_new", n16, 0);
        to(199); scal[0] = 1; chk("t2_gate_199", g16, 1);
        to(200); scal[0] = 0; rd = 1; addr = 5'd0;
        to(201); chk("t2_rd0", d16, 2); addr = 5'd31;
        to(202); chk("t3_rd31_16", d16, 20); chk("t3_sat16", s16, 0);
        chk("t3_rd31_4", d4, 15); chk("t3_sat4", s4, 1);
        rd = 0;

        // Quiet window, then the overrun flag sequence.
        to(300); chk("t4_new", n16, 1); chk("t4_missed", m16, 1);
        rd = 1; addr = 5'd0;
        to(301); chk("t2_rd0_next", d16, 0); addr = 5'd31;
        to(302); chk("t3_rd31_quiet", d4, 0); chk("t3_sat4_quiet", s4, 0);
        rd = 0;
        to(399); ack = 1; chk("t4_gate_399", g16, 1);
        to(400); ack = 0; chk("t4_new_keep", n16, 1); chk("t4_missed_keep", m16, 1);
        to(410); ack = 1;
        to(411); ack = 0; chk("t4_new_clr", n16, 0); chk("t4_missed_clr", m16, 0);

        // PPS gating, pulses 37 cycles apart.
        to(420); use_pps = 1;
        to(430); pps = 1;
        to(431); pps = 0; chk("t5_gate_431", g16, 1);
        for (int t = 440; t < 450; t++) begin
            to(t);
            scal[7] = (t % 2 == 0);
        end
        to(450); scal[7] = 0;
        to(467); pps = 1;
        to(468); pps = 0; chk("t5_gate_468", g16, 1);
        to(470); rd = 1; addr = 5'd7;
        to(471); chk("t5_rd7", d16, 5); rd = 0;
        to(568); chk("t5_no_period_gate", g16, 0);
        to(570); use_pps = 0;

        // Reset mid-gate discards partial counts.
        for (int t = 580; t < 596; t++) begin
            to(t);
            scal[9] = (t % 2 == 0);
        end
        to(596); scal[9] = 0;
        to(600); scal[20] = 1; rst = 1;
        step(); chk_zero("rst_a");
        step(); chk_zero("rst_b");
        rst = 0;
        tcyc = 0;
        for (int t = 10; t < 16; t++) begin
            to(t);
            scal[9] = (t % 2 == 0);
        end
        to(16); scal[9] = 0;
        to(99); rd = 1; addr = 5'd9; chk("t6_gate_99", g16, 1);
        to(100); chk("t6_rd_on_gate", d16, 0);
        to(101); chk("t6_rd9", d16, 3); addr = 5'd20;
        to(102); chk("t6_rd20_high_at_release", d16, 1); rd = 0;
        to(150); scal[9] = 1;
        to(151); scal[9] = 0;
        to(199); rd = 1; addr = 5'd9;
        to(200); chk("t6_rd_old", d16, 3);
        to(201); chk("t6_rd_new", d16, 1); rd = 0;
        to(205);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scaler_accumulator.md
Name: scaler_accumulator

Overview:
- Sits directly downstream of the TURF trigger processor.
- Consumes its 32-bit scaler vector: L0 tunnel-diode scalers, L1/L2 scalers and the registered reference pulse.
- Counts rising edges per channel over a fixed gate window, either an internal period or an external PPS.
- Latches a full bank of counts at each gate end and serves it to the housekeeping readout through a registered address/strobe port with new-data and overrun flags.

Parameters:
- NCH, 32, number of scaler channels; readout address width is 5 bits.
- WIDTH, 16, counter and latch width per channel.
- PERIOD, 33000000, gate length in clk_i cycles for internal gating (1 s at 33 MHz); the period counter is 26 bits.

Ports:
- clk_i  input  1  master clock (33 MHz); all logic is on this edge.
- rst_i  input  1  reset, asynchronous, active-high.
- scal_i  input  NCH  scaler inputs, synchronous to clk_i, level or pulse.
- pps_i  input  1  external gate pulse, synchronous to clk_i.
- use_pps_i  input  1  gate source select: 1 = pps_i rising edge, 0 = internal PERIOD.
- rd_i  input  1  read strobe.
- addr_i  input  5  channel to read.
- ack_i  input  1  host acknowledge of the latched bank.
- dat_o  output  WIDTH  read data.
- dat_valid_o  output  1  read data valid.
- sat_o  output  1  the addressed channel saturated in the latched bank.
- new_o  output  1  a new bank has been latched and is unacknowledged.
- missed_o  output  1  sticky overrun flag.
- gate_o  output  1  one-cycle pulse on every gate end.

Behaviour:
- Reset (async, rst_i=1) clears:
  - all counters and latches;
  - the input delay register scal_q and the pps delay register;
  - the period counter;
  - dat_o, dat_valid_o, sat_o, new_o, missed_o, gate_o.
  - A reset mid-gate discards partial counts. The first gate after release is a full PERIOD, or ends at the next pps edge.
- Edge detect:
  - edge[n] = scal_i[n] & ~scal_q[n]; scal_q <= scal_i every cycle.
  - An input already high when reset releases counts one edge on the first cycle.
  - An input held high counts once.
  - Back-to-back single-cycle pulses separated by one low cycle count 2.
- Counters:
  - Each clk_i cycle with edge[n]=1 increments cnt[n] by 1.
  - cnt[n] saturates at 2^WIDTH-1 and never wraps.
- Gate end, internal mode (use_pps_i=0):
  - The period counter counts 0..PERIOD-1.
  - Gate end occurs on the cycle it equals PERIOD-1; the counter then returns to 0.
- Gate end, PPS mode (use_pps_i=1):
  - Gate end occurs on the cycle a registered rising edge of pps_i is detected, i.e. one cycle after pps_i rises.
  - The period counter is cleared on each pps gate end and does not generate gates.
- Changing use_pps_i mid-gate takes effect on the next cycle with no extra gate.
- On a gate-end cycle:
  - latch[n] <= saturating(cnt[n] + edge[n]), so the edge in the gate-end cycle belongs to the closing window.
  - cnt[n] <= 0.
  - satl[n] <= 1 if the latched value equals 2^WIDTH-1.
  - gate_o = 1 for exactly that cycle.
- Readout:
  - rd_i=1 at cycle t returns dat_o=latch[addr_i] and sat_o=satl[addr_i] with dat_valid_o=1 at t+1.
  - dat_valid_o is 0 otherwise; dat_o holds its last value.
  - A read coincident with a gate end returns the pre-update latch value.
  - Reads may be issued every cycle.
- Flags:
  - new_o sets on gate end and clears on ack_i; a simultaneous gate end and ack_i leaves new_o=1.
  - missed_o sets when a gate end occurs while new_o=1 and ack_i=0.
  - missed_o stays set until an ack_i with no simultaneous gate end, or until reset.

Test Plan:
1. PERIOD=100, use_pps_i=0, 10 single-cycle pulses on scal_i[3] in gate 1 -> gate_o at cycle 99; read addr 3 returns 10 with dat_valid_o one cycle after rd_i; other channels read 0; new_o=1.
2. scal_i[0] held high for 50 cycles, then a pulse landing exactly on the gate-end cycle -> latch[0]=2; next-window count starts at 0.
3. WIDTH=4, 20 edges on scal_i[31] in one gate -> latch=15, sat_o=1 on read of addr 31; next quiet gate -> 0, sat_o=0.
4. No ack_i across two gate ends -> missed_o=1 after the second; ack_i on the same cycle as the third gate end -> new_o=1, missed_o stays 1; a later lone ack_i -> both 0.
5. use_pps_i=1, pps_i pulses 37 cycles apart with 5 edges on channel 7 between -> gate_o 1 cycle after each pps rise; latch[7]=5; no gate at cycle PERIOD-1.
6. rst_i asserted mid-gate after 8 edges, then released, then 3 edges -> all outputs 0 during reset; next latch shows 3; rd_i on the gate-end cycle returns the old value.
